// File: rtl/wb_mem_bridge.sv
// Bridges the CPU valid/ready memory port to a single-master classic Wishbone bus.
// One access in flight; a cycle-count timeout completes accesses to slaves that never ACK.
module wb_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic             stb_q, stb_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    stb_d   = stb_q;
    ready_d = ready_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          adr_d   = mem_addr;
          dat_d   = mem_wdata;
          we_d    = |mem_wstrb;
          sel_d   = (|mem_wstrb) ? mem_wstrb : 4'hF;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // ACK takes priority over the timeout in the final wait cycle
        if (wb_ack_i) begin
          stb_d   = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : wb_dat_i;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          stb_d   = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'hFFFF_FFFF;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        stb_d   = 1'b0;
        ready_d = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      stb_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      stb_q   <= stb_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = stb_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_wb_mem_bridge.sv
// Scoreboard bench for wb_mem_bridge: directed accesses push expected completions,
// a negedge monitor pops and compares them whenever mem_ready pulses.
module tb_wb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  wb_mem_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_err(mem_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_n    = 0;

  // slave modes: 0 = ACK one cycle after STB, 1 = never ACK, 2 = ACK in 4th STB cycle
  int   slave_mode = 0;
  int   stb_seen   = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(posedge clk) begin
    if (wb_stb_o === 1'b1) stb_seen <= stb_seen + 1;
    else                   stb_seen <= 0;
    case (slave_mode)
      0:       wb_ack_i <= (wb_stb_o === 1'b1) && !wb_ack_i;
      2:       wb_ack_i <= (wb_stb_o === 1'b1) && (stb_seen == 2);
      default: wb_ack_i <= 1'b0;
    endcase
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ready: got ready at cycle %0d, expected none", cyc_n);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdata", mem_rdata, e.rdata);
        chk("err", {31'd0, mem_err}, {31'd0, e.err});
        chk("ready_cycle", cyc_n, e.cyc);
      end
    end
  end

  // ready appears 'lat' negedges after the negedge where the request was driven
  task automatic expect_resp(logic [31:0] rd, logic er, int lat);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    e.cyc   = cyc_n + lat;
    exp_q.push_back(e);
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_addr  = 32'hDEAD_BEEF;
    mem_wdata = 32'hCAFE_F00D;
    mem_wstrb = 4'h5;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int stb_cnt;
    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    wb_dat_i  = '0;
    wb_ack_i  = 1'b0;

    // reset
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_ctrl", {26'd0, wb_we_o, wb_sel_o, wb_stb_o}, 32'd0);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // write: bus stable 2 cycles, ready 3 cycles after valid, rdata 0
    wb_dat_i = 32'h1234_5678;
    expect_resp(32'h0, 1'b0, 3);
    issue(32'h2, 32'h1, 4'hF);
    chk("wr_adr", wb_adr_o, 32'h2);
    chk("wr_dat", wb_dat_o, 32'h1);
    chk("wr_we_sel_stb", {26'd0, wb_we_o, wb_sel_o, wb_stb_o}, {26'd0, 1'b1, 4'hF, 1'b1});
    chk("wr_cyc", {31'd0, wb_cyc_o}, 32'd1);
    @(negedge clk);
    chk("wr_adr_hold", wb_adr_o, 32'h2);
    chk("wr_stb_hold", {30'd0, wb_stb_o, wb_cyc_o}, 32'd3);
    @(negedge clk);
    chk("wr_stb_drop", {30'd0, wb_stb_o, wb_cyc_o}, 32'd0);
    drain();

    // read: slave returns 0x1
    wb_dat_i = 32'h1;
    expect_resp(32'h1, 1'b0, 3);
    issue(32'h1, 32'h0, 4'h0);
    chk("rd_adr", wb_adr_o, 32'h1);
    chk("rd_we_sel", {27'd0, wb_we_o, wb_sel_o}, {27'd0, 1'b0, 4'hF});
    drain();

    // partial write strobe drives SEL directly
    expect_resp(32'h0, 1'b0, 3);
    issue(32'h40, 32'hA5A5_A5A5, 4'b0110);
    chk("pw_sel", {28'd0, wb_sel_o}, 32'h6);
    drain();

    // timeout: no ACK, STB high exactly 4 cycles, then err
    slave_mode = 1;
    expect_resp(32'hFFFF_FFFF, 1'b1, 5);
    issue(32'h100, 32'h0, 4'h0);
    stb_cnt = (wb_stb_o === 1'b1) ? 1 : 0;
    repeat (7) begin
      @(negedge clk);
      if (wb_stb_o === 1'b1) stb_cnt++;
    end
    chk("to_stb_cycles", stb_cnt, 32'd4);
    drain();

    // ACK in the last wait cycle wins over the timeout
    slave_mode = 2;
    wb_dat_i   = 32'h0BAD_F00D;
    expect_resp(32'h0BAD_F00D, 1'b0, 5);
    issue(32'h104, 32'h0, 4'h0);
    drain();

    // reset mid-BUS: bus drops, no completion
    slave_mode = 1;
    issue(32'h200, 32'h0, 4'h0);
    chk("mid_stb_before", {31'd0, wb_stb_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_stb_after", {30'd0, wb_stb_o, wb_cyc_o}, 32'd0);
    repeat (8) @(negedge clk);
    slave_mode = 0;
    wb_dat_i   = 32'h0000_0077;
    expect_resp(32'h77, 1'b0, 3);
    issue(32'h204, 32'h0, 4'h0);
    drain();

    // back-to-back: mem_valid held high, one completion every 4 cycles
    wb_dat_i  = 32'h0000_0042;
    mem_addr  = 32'h300;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    expect_resp(32'h42, 1'b0, 3);
    expect_resp(32'h42, 1'b0, 7);
    expect_resp(32'h42, 1'b0, 11);
    repeat (10) @(negedge clk);
    mem_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
